seq_magnitude_comparator: RTL

SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

---
 rtl/seq_cmp_pkg.sv | 22 ++
 rtl/slice_comparator.sv | 18 +
 rtl/seq_magnitude_comparator.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seq_cmp_pkg.sv
// Shared encodings for the sequential magnitude comparator: FSM states and
// the one-hot G/E/L result word.
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  // Result word is {G, E, L}; all-zero means no comparison has completed yet
  typedef logic [2:0] cmp_result_t;
  localparam cmp_result_t RES_NONE = 3'b000;
  localparam cmp_result_t RES_GT   = 3'b100;
  localparam cmp_result_t RES_EQ   = 3'b010;
  localparam cmp_result_t RES_LT   = 3'b001;

  function automatic cmp_result_t unequal_result(input logic gt);
    return gt ? RES_GT : RES_LT;
  endfunction

endpackage

// File: rtl/slice_comparator.sv
// Stateless magnitude compare of one SLICE_W-bit slice pair.
module slice_comparator
  import seq_cmp_pkg::*;
#(
  parameter int SLICE_W = 2
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic               gt,
  output logic               eq,
  output logic               lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Compares two WIDTH-bit operands SLICE_W bits per cycle, MSB slice first,
// stopping at the first unequal slice. Define SEQ_CMP_SIGNED_EN to add signed_mode.
module seq_magnitude_comparator
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SLICE_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SEQ_CMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             G,
  output logic             E,
  output logic             L
);

  localparam int NS    = WIDTH / SLICE_W;
  localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [SLICE_W-1:0] TOP_MASK = SLICE_W'(1) << (SLICE_W - 1);

  cmp_state_t  state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [IDX_W-1:0] index_reg, index_next;
  cmp_result_t result_reg, result_next;
  logic        flip;

`ifdef SEQ_CMP_SIGNED_EN
  logic signed_reg, signed_next;
  assign flip = signed_reg;
`else
  assign flip = 1'b0;
`endif

  // Two's complement ordering equals unsigned ordering with the sign bit inverted
  logic [SLICE_W-1:0] a_slice_arr [NS];
  logic [SLICE_W-1:0] b_slice_arr [NS];

  for (genvar gi = 0; gi < NS; gi++) begin : g_slice
    if (gi == NS - 1) begin : g_top
      assign a_slice_arr[gi] = a_reg[gi*SLICE_W +: SLICE_W] ^ (flip ? TOP_MASK : '0);
      assign b_slice_arr[gi] = b_reg[gi*SLICE_W +: SLICE_W] ^ (flip ? TOP_MASK : '0);
    end else begin : g_low
      assign a_slice_arr[gi] = a_reg[gi*SLICE_W +: SLICE_W];
      assign b_slice_arr[gi] = b_reg[gi*SLICE_W +: SLICE_W];
    end
  end

  logic slice_gt, slice_eq, slice_lt;

  slice_comparator #(
    .SLICE_W (SLICE_W)
  ) u_slice_cmp (
    .a  (a_slice_arr[index_reg]),
    .b  (b_slice_arr[index_reg]),
    .gt (slice_gt),
    .eq (slice_eq),
    .lt (slice_lt)
  );

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    index_next  = index_reg;
    result_next = result_reg;
`ifdef SEQ_CMP_SIGNED_EN
    signed_next = signed_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = a;
          b_next     = b;
          index_next = IDX_W'(NS - 1);
`ifdef SEQ_CMP_SIGNED_EN
          signed_next = signed_mode;
`endif
          state_next = RUN;
        end
      end
      RUN: begin
        if (!slice_eq) begin
          result_next = unequal_result(slice_gt);
          state_next  = DONE;
        end else if (index_reg == '0) begin
          result_next = RES_EQ;
          state_next  = DONE;
        end else begin
          index_next = index_reg - IDX_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      index_reg  <= '0;
      result_reg <= RES_NONE;
`ifdef SEQ_CMP_SIGNED_EN
      signed_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      index_reg  <= index_next;
      result_reg <= result_next;
`ifdef SEQ_CMP_SIGNED_EN
      signed_reg <= signed_next;
`endif
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign G    = result_reg[2];
  assign E    = result_reg[1];
  assign L    = result_reg[0];

  // slice_lt is implied by !gt && !eq; kept on the port for completeness
  logic unused_lt;
  assign unused_lt = slice_lt;

endmodule
